cr_tlvp_spl: RTL and testbench

CR_TLVP_SPL -- requirements
Module: cr_tlvp_spl
Interface
REQ-001 SHALL have parameter USR_TYPE_MASK, default 32'h0: bit n=1 routes TLV type n to the user path.
REQ-002 SHALL have parameter ORD_INIT, default 1: ordern assigned to the first TLV of each frame.
REQ-003 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, async active-low reset); one clock, reset asynchronous and active-low.
REQ-004 SHALL have ports axi_ib_empty (in, 1), axi_ib (in, axi4s_dp_bus_t) and axi_ib_rd (out, 1): inbound FIFO read side, data valid while ~axi_ib_empty.
REQ-005 SHALL have ports pt_ib_afull (in, 1), pt_ib_wr (out, 1) and pt_ib_tlv (out, tlvp_if_bus_t): pass-through write side.
REQ-006 SHALL have ports usr_ib_afull (in, 1), usr_ib_wr (out, 1) and usr_ib_tlv (out, tlvp_if_bus_t): user write side.
REQ-007 SHALL have port tlvp_spl_err (out, 3): one-cycle pulses {bip2, len, trunc}.
Function
REQ-008 SHALL run the state machine WAIT_SOT, IN_TLV, DROP.
REQ-009 In WAIT_SOT, SHALL treat a word with tuser[0]=1 as TLV word 0, decoded as tlv_word_0_t (tlv_type, tlv_len in 64-bit words including word 0).
REQ-010 In WAIT_SOT, SHALL select dest=user when tlv_type<32 and USR_TYPE_MASK[tlv_type]=1, else pass-through; dest SHALL be latched for the whole TLV.
REQ-011 SHALL load remaining=tlv_len-1 on word 0 and decrement it per word in IN_TLV.
REQ-012 SHALL go to IN_TLV when remaining>0 and stay in WAIT_SOT when tlv_len=1.
REQ-013 SHALL set sot=1 on word 0 only and eot=1 on the word where remaining reaches 0.
REQ-014 SHALL copy tlast, tid, tstrb, tuser and tdata unchanged, and set typen=tlv_type, ordern=current ordern and insert=0.
REQ-015 SHALL assert axi_ib_rd = ~axi_ib_empty & ~afull(dest); for word 0, dest is the combinationally decoded destination.
REQ-016 SHALL register the write outputs with exactly one cycle of latency: axi_ib_rd at cycle N gives *_ib_wr=1 at cycle N+1.
REQ-017 SHALL never assert pt_ib_wr and usr_ib_wr in the same cycle.
REQ-018 SHALL increment ordern on every eot; ordern SHALL wrap modulo 2^TLVP_ORD_NUM_WIDTH with no saturation.
REQ-019 SHALL reload ordern to ORD_INIT on any consumed word with tlast=1, with priority over the eot increment.
REQ-020 If tlast=1 arrives while remaining>0, SHALL force eot=1 on that word, pulse trunc and return to WAIT_SOT.
REQ-021 If tlast=1 and eot coincide, SHALL treat it as a normal end with no error.
REQ-022 If tlv_len=0, SHALL pulse len, write nothing and enter DROP; a tlv_len=0 word with tlast=1 SHALL stay in WAIT_SOT.
REQ-023 In WAIT_SOT, SHALL discard a word with tuser[0]=0, pulse len and enter DROP.
REQ-024 DROP SHALL consume and discard words regardless of afull, and exit to WAIT_SOT after the tlast word.
REQ-025 In IN_TLV, a word with tuser[0]=1 SHALL be treated as data (no resync).
Reset
REQ-026 While rst_n=0: state=WAIT_SOT, ordern=ORD_INIT, remaining=0, dest=pass-through.
REQ-027 While rst_n=0: pt_ib_wr=0, usr_ib_wr=0, both tlv buses all-zero, tlvp_spl_err=0, axi_ib_rd=0.
REQ-028 Reset asserted mid-TLV SHALL abandon the TLV with no trailing eot; the first word after reset SHALL be decoded in WAIT_SOT.
Configuration
REQ-029 With TLVP_SPL_BIP2_CHK_EN defined, SHALL compute bip2 over {2'b00, tdata[61:0]} of word 0.
REQ-030 With TLVP_SPL_BIP2_CHK_EN defined, SHALL pulse err bit bip2 on a mismatch with tdata[63:62] and still forward the TLV.
REQ-031 Without TLVP_SPL_BIP2_CHK_EN, there SHALL be no checker logic and tlvp_spl_err[2] SHALL be tied 0.
Structure
REQ-032 tlv_word_0_t, tlvp_if_bus_t, axi4s_dp_bus_t and TLVP_ORD_NUM_WIDTH SHALL come from the shared cr_structs package.
REQ-033 State enum and error-bit index constants SHALL be local.
REQ-034 The bip2 function SHALL be the common std-macro function.
REQ-035 SHALL contain no sub-module, no internal FIFO and at most one output register stage.
Verification
REQ-036 Frame with TLVs type 1 len 3, type 5 len 1 with tlast, USR_TYPE_MASK=32'h20 -> 3 pt words ordern 1 (sot w0, eot w2), then 1 usr word ordern 2 with sot=eot=tlast=1.
REQ-037 pt_ib_afull=1 held 10 cycles mid-TLV -> axi_ib_rd=0 and no writes throughout; stream resumes with no loss or duplication.
REQ-038 tlast on word 2 of a len-5 TLV -> that word written with eot=1, trunc pulse; next frame's first TLV gets ordern 1.
REQ-039 Word 0 with tlv_len=0, then 3 words, the last with tlast -> len pulse, zero writes, then normal decode.
REQ-040 TLVP_SPL_BIP2_CHK_EN defined, word 0 with corrupted tdata[63] -> bip2 pulse and TLV still forwarded intact.
REQ-041 2^TLVP_ORD_NUM_WIDTH+1 len-1 TLVs with no tlast -> ordern wraps to 0 and then 1.

---
 rtl/cr_structs.sv | 54 +++++
 rtl/cr_tlvp_spl.sv | 211 +++++++++++++++++++++
 tb/tb_cr_tlvp_spl.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_structs.sv
// ============================================================================
// Module      : cr_structs
// Description : Shared AXI4-Stream / TLV bus types, widths and the bip2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cr_structs;

    localparam int TLVP_ORD_NUM_WIDTH = 4;

    typedef struct packed {
        logic        tlast;
        logic [7:0]  tid;
        logic [7:0]  tstrb;
        logic [7:0]  tuser;
        logic [63:0] tdata;
    } axi4s_dp_bus_t;

    typedef struct packed {
        logic                          insert;
        logic [TLVP_ORD_NUM_WIDTH-1:0] ordern;
        logic [7:0]                    typen;
        logic                          sot;
        logic                          eot;
        logic                          tlast;
        logic [7:0]                    tid;
        logic [7:0]                    tstrb;
        logic [7:0]                    tuser;
        logic [63:0]                   tdata;
    } tlvp_if_bus_t;

    // tlv_len counts 64-bit words and includes this header word.
    typedef struct packed {
        logic [1:0]  tlv_bip2;
        logic [29:0] rsvd;
        logic [23:0] tlv_len;
        logic [7:0]  tlv_type;
    } tlv_word_0_t;

    // Bit 0 is parity of the even data bits, bit 1 of the odd data bits.
    function automatic logic [1:0] bip2_64(input logic [63:0] data);
        logic [1:0] acc;
        acc = 2'b00;
        for (int i = 0; i < 64; i += 2) begin
            acc[0] = acc[0] ^ data[i];
            acc[1] = acc[1] ^ data[i+1];
        end
        return acc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cr_tlvp_spl.sv
// ============================================================================
// Module      : cr_tlvp_spl
// Description : Splits an inbound TLV stream into pass-through and user paths.
//               Optional header bip2 check enabled by TLVP_SPL_BIP2_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cr_tlvp_spl
    import cr_structs::*;
#(
    parameter logic [31:0]                   USR_TYPE_MASK = 32'h0,
    parameter logic [TLVP_ORD_NUM_WIDTH-1:0] ORD_INIT      = TLVP_ORD_NUM_WIDTH'(1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          axi_ib_empty,
    input  axi4s_dp_bus_t axi_ib,
    output logic          axi_ib_rd,
    input  logic          pt_ib_afull,
    output logic          pt_ib_wr,
    output tlvp_if_bus_t  pt_ib_tlv,
    input  logic          usr_ib_afull,
    output logic          usr_ib_wr,
    output tlvp_if_bus_t  usr_ib_tlv,
    output logic [2:0]    tlvp_spl_err
);

    typedef enum logic [1:0] {
        ST_WAIT_SOT = 2'd0,
        ST_IN_TLV   = 2'd1,
        ST_DROP     = 2'd2
    } state_e;

    localparam int ERR_TRUNC = 0;
    localparam int ERR_LEN   = 1;
    localparam int ERR_BIP2  = 2;

    state_e                        state_q, state_d;
    logic [TLVP_ORD_NUM_WIDTH-1:0] ordern_q, ordern_d;
    logic [23:0]                   remaining_q, remaining_d;
    logic                          dest_usr_q, dest_usr_d;
    logic [7:0]                    type_q, type_d;

    logic                          pt_wr_q, usr_wr_q;
    tlvp_if_bus_t                  pt_tlv_q, usr_tlv_q;
    logic [2:0]                    err_q, err_d;

    tlv_word_0_t                   w_w0;
    logic                          w_dec_usr;
    logic                          w_rd;
    logic                          w_wr;
    logic                          w_wr_usr;
    logic                          w_sot;
    logic                          w_eot;
    logic [7:0]                    w_typen;
    tlvp_if_bus_t                  w_bus;
    logic                          w_unused;

    assign w_w0      = tlv_word_0_t'(axi_ib.tdata);
    assign w_dec_usr = (w_w0.tlv_type < 8'd32) && USR_TYPE_MASK[w_w0.tlv_type[4:0]];

`ifdef TLVP_SPL_BIP2_CHK_EN
    logic [1:0] w_bip2_calc;
    assign w_bip2_calc = bip2_64({2'b00, axi_ib.tdata[61:0]});
    assign w_unused    = ^w_w0.rsvd;
`else
    assign w_unused    = ^{w_w0.tlv_bip2, w_w0.rsvd};
`endif

    always_comb begin
        state_d     = state_q;
        ordern_d    = ordern_q;
        remaining_d = remaining_q;
        dest_usr_d  = dest_usr_q;
        type_d      = type_q;
        err_d       = 3'b000;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        w_wr_usr    = dest_usr_q;
        w_sot       = 1'b0;
        w_eot       = 1'b0;
        w_typen     = type_q;

        case (state_q)
            ST_WAIT_SOT: begin
                if (!axi_ib_empty) begin
                    if (axi_ib.tuser[0] && (w_w0.tlv_len != 24'd0)) begin
                        // Header stalls on the freshly decoded destination's afull.
                        w_rd = w_dec_usr ? ~usr_ib_afull : ~pt_ib_afull;
                        if (w_rd) begin
                            w_wr       = 1'b1;
                            w_wr_usr   = w_dec_usr;
                            dest_usr_d = w_dec_usr;
                            type_d     = w_w0.tlv_type;
                            w_typen    = w_w0.tlv_type;
                            w_sot      = 1'b1;
                            w_eot      = (w_w0.tlv_len == 24'd1) || axi_ib.tlast;
                            err_d[ERR_TRUNC] = axi_ib.tlast && (w_w0.tlv_len != 24'd1);
`ifdef TLVP_SPL_BIP2_CHK_EN
                            err_d[ERR_BIP2]  = (w_bip2_calc != w_w0.tlv_bip2);
`endif
                            if (w_eot) begin
                                remaining_d = 24'd0;
                            end else begin
                                remaining_d = w_w0.tlv_len - 24'd1;
                                state_d     = ST_IN_TLV;
                            end
                        end
                    end else begin
                        // Bad header or zero length: nothing is written, so no backpressure.
                        w_rd           = 1'b1;
                        err_d[ERR_LEN] = 1'b1;
                        if (!axi_ib.tlast) begin
                            state_d = ST_DROP;
                        end
                    end
                end
            end

            ST_IN_TLV: begin
                if (!axi_ib_empty) begin
                    w_rd = dest_usr_q ? ~usr_ib_afull : ~pt_ib_afull;
                    if (w_rd) begin
                        w_wr             = 1'b1;
                        w_eot            = (remaining_q == 24'd1) || axi_ib.tlast;
                        err_d[ERR_TRUNC] = axi_ib.tlast && (remaining_q != 24'd1);
                        if (w_eot) begin
                            remaining_d = 24'd0;
                            state_d     = ST_WAIT_SOT;
                        end else begin
                            remaining_d = remaining_q - 24'd1;
                        end
                    end
                end
            end

            ST_DROP: begin
                if (!axi_ib_empty) begin
                    w_rd = 1'b1;
                    if (axi_ib.tlast) begin
                        state_d = ST_WAIT_SOT;
                    end
                end
            end

            default: begin
                state_d = ST_WAIT_SOT;
            end
        endcase

        if (w_rd && axi_ib.tlast) begin
            ordern_d = ORD_INIT;
        end else if (w_wr && w_eot) begin
            ordern_d = ordern_q + TLVP_ORD_NUM_WIDTH'(1);
        end

        w_bus        = '0;
        w_bus.insert = 1'b0;
        w_bus.ordern = ordern_q;
        w_bus.typen  = w_typen;
        w_bus.sot    = w_sot;
        w_bus.eot    = w_eot;
        w_bus.tlast  = axi_ib.tlast;
        w_bus.tid    = axi_ib.tid;
        w_bus.tstrb  = axi_ib.tstrb;
        w_bus.tuser  = axi_ib.tuser;
        w_bus.tdata  = axi_ib.tdata;
    end

    assign axi_ib_rd = w_rd & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT_SOT;
            ordern_q    <= ORD_INIT;
            remaining_q <= 24'd0;
            dest_usr_q  <= 1'b0;
            type_q      <= 8'd0;
            pt_wr_q     <= 1'b0;
            usr_wr_q    <= 1'b0;
            pt_tlv_q    <= '0;
            usr_tlv_q   <= '0;
            err_q       <= 3'b000;
        end else begin
            state_q     <= state_d;
            ordern_q    <= ordern_d;
            remaining_q <= remaining_d;
            dest_usr_q  <= dest_usr_d;
            type_q      <= type_d;
            pt_wr_q     <= w_wr & ~w_wr_usr;
            usr_wr_q    <= w_wr & w_wr_usr;
            err_q       <= err_d;
            if (w_wr && !w_wr_usr) begin
                pt_tlv_q <= w_bus;
            end
            if (w_wr && w_wr_usr) begin
                usr_tlv_q <= w_bus;
            end
        end
    end

    assign pt_ib_wr     = pt_wr_q;
    assign usr_ib_wr    = usr_wr_q;
    assign pt_ib_tlv    = pt_tlv_q;
    assign usr_ib_tlv   = usr_tlv_q;
    assign tlvp_spl_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cr_tlvp_spl.sv
// ============================================================================
// Module      : tb_cr_tlvp_spl
// Description : Self-checking bench for cr_tlvp_spl (honours TLVP_SPL_BIP2_CHK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cr_tlvp_spl;
    import cr_structs::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          axi_ib_empty;
    axi4s_dp_bus_t axi_ib;
    logic          axi_ib_rd;
    logic          pt_ib_afull;
    logic          pt_ib_wr;
    tlvp_if_bus_t  pt_ib_tlv;
    logic          usr_ib_afull;
    logic          usr_ib_wr;
    tlvp_if_bus_t  usr_ib_tlv;
    logic [2:0]    tlvp_spl_err;

    cr_tlvp_spl #(
        .USR_TYPE_MASK (32'h20),
        .ORD_INIT      (4'd1)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .axi_ib_empty (axi_ib_empty),
        .axi_ib       (axi_ib),
        .axi_ib_rd    (axi_ib_rd),
        .pt_ib_afull  (pt_ib_afull),
        .pt_ib_wr     (pt_ib_wr),
        .pt_ib_tlv    (pt_ib_tlv),
        .usr_ib_afull (usr_ib_afull),
        .usr_ib_wr    (usr_ib_wr),
        .usr_ib_tlv   (usr_ib_tlv),
        .tlvp_spl_err (tlvp_spl_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           usr;
        tlvp_if_bus_t bus;
    } exp_t;

    typedef struct {
        logic [7:0] typ;
        int         len;
        bit         last;
        bit         usr;
        logic [3:0] ord;
    } vec_t;

    axi4s_dp_bus_t src_q[$];
    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            wr_cnt = 0;
    int            trunc_cnt = 0;
    int            len_cnt = 0;
    int            bip_cnt = 0;

    function automatic logic [1:0] tb_bip2(input logic [63:0] d);
        return {^(d & 64'hAAAA_AAAA_AAAA_AAAA), ^(d & 64'h5555_5555_5555_5555)};
    endfunction

    // Inbound FIFO model: front word shown while non-empty, popped after a read.
    initial begin
        bit take;
        axi_ib       = '0;
        axi_ib_empty = 1'b1;
        forever begin
            @(negedge clk);
            take = axi_ib_rd;
            @(posedge clk);
            #1;
            if (take && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0) begin
                axi_ib       = src_q[0];
                axi_ib_empty = 1'b0;
            end else begin
                axi_ib_empty = 1'b1;
            end
        end
    end

    // Output monitor and scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tlvp_spl_err[0]) trunc_cnt++;
            if (tlvp_spl_err[1]) len_cnt++;
            if (tlvp_spl_err[2]) bip_cnt++;
            if (pt_ib_wr && usr_ib_wr) begin
                checks++;
                errors++;
                $display("FAIL both_wr: pt_ib_wr=%0b usr_ib_wr=%0b, required not both", pt_ib_wr, usr_ib_wr);
            end else if (pt_ib_wr || usr_ib_wr) begin
                tlvp_if_bus_t got;
                exp_t         e;
                got = pt_ib_wr ? pt_ib_tlv : usr_ib_tlv;
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wr: usr=%0b bus=%h, required no write", usr_ib_wr, got);
                end else begin
                    e = exp_q.pop_front();
                    if (usr_ib_wr !== e.usr || got !== e.bus) begin
                        errors++;
                        $display("FAIL wr_word: usr=%0b bus=%h, required usr=%0b bus=%h",
                                 usr_ib_wr, got, e.usr, e.bus);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic push_raw(input logic [63:0] d, input logic [7:0] tu, input bit last);
        axi4s_dp_bus_t w;
        w.tdata = d;
        w.tuser = tu;
        w.tlast = last;
        w.tid   = 8'h5a;
        w.tstrb = 8'hff;
        src_q.push_back(w);
    endtask

    task automatic push_tlv(input logic [7:0] typ, input int len, input int nwords, input bit last,
                            input bit usr, input logic [3:0] ord, input bit corrupt);
        for (int i = 0; i < nwords; i++) begin
            axi4s_dp_bus_t w;
            exp_t          e;
            logic [63:0]   d;
            if (i == 0) begin
                d        = {2'b00, 30'h0, 24'(len), typ};
                d[63:62] = tb_bip2({2'b00, d[61:0]});
                if (corrupt) d[63] = ~d[63];
                w.tuser  = 8'h01;
            end else begin
                d       = {$urandom, $urandom};
                w.tuser = (i == 1) ? 8'h01 : 8'h00;
            end
            w.tdata = d;
            w.tid   = 8'(i) + typ;
            w.tstrb = 8'hff;
            w.tlast = last && (i == nwords - 1);
            src_q.push_back(w);
            e.usr        = usr;
            e.bus        = '0;
            e.bus.insert = 1'b0;
            e.bus.ordern = ord;
            e.bus.typen  = typ;
            e.bus.sot    = (i == 0);
            e.bus.eot    = (i == nwords - 1);
            e.bus.tlast  = w.tlast;
            e.bus.tid    = w.tid;
            e.bus.tstrb  = w.tstrb;
            e.bus.tuser  = w.tuser;
            e.bus.tdata  = w.tdata;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (src_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: src=%0d exp=%0d left, required 0", nm, src_q.size(), exp_q.size());
        end
    endtask

    task automatic wait_wr(input int target, input string nm);
        int n = 0;
        while (wr_cnt < target && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (wr_cnt < target) begin
            errors++;
            $display("FAIL %s_timeout: writes=%0d, required %0d", nm, wr_cnt, target);
        end
    endtask

    initial begin
        vec_t vt[9];
        int   base;
        int   snap;

        vt[0] = '{8'd1,  3, 1'b0, 1'b0, 4'd1};
        vt[1] = '{8'd5,  1, 1'b1, 1'b1, 4'd2};
        vt[2] = '{8'd37, 2, 1'b0, 1'b0, 4'd1};
        vt[3] = '{8'd5,  2, 1'b0, 1'b1, 4'd2};
        vt[4] = '{8'd0,  1, 1'b0, 1'b0, 4'd3};
        vt[5] = '{8'd31, 1, 1'b0, 1'b0, 4'd4};
        vt[6] = '{8'd5,  3, 1'b1, 1'b1, 4'd5};
        vt[7] = '{8'd5,  1, 1'b0, 1'b1, 4'd1};
        vt[8] = '{8'd2,  2, 1'b1, 1'b0, 4'd2};

        rst_n        = 1'b0;
        pt_ib_afull  = 1'b0;
        usr_ib_afull = 1'b0;
        push_tlv(vt[0].typ, vt[0].len, vt[0].len, vt[0].last, vt[0].usr, vt[0].ord, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_rd", axi_ib_rd, 0);
        chk("rst_pt_wr", pt_ib_wr, 0);
        chk("rst_usr_wr", usr_ib_wr, 0);
        chk("rst_pt_tlv", |pt_ib_tlv, 0);
        chk("rst_usr_tlv", |usr_ib_tlv, 0);
        chk("rst_err", tlvp_spl_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 1; k < 9; k++)
            push_tlv(vt[k].typ, vt[k].len, vt[k].len, vt[k].last, vt[k].usr, vt[k].ord, 1'b0);
        drain("table");
        chk("table_trunc", trunc_cnt, 0);
        chk("table_len", len_cnt, 0);

        // User path full: pass-through TLV flows, user header stalls on its own afull.
        usr_ib_afull = 1'b1;
        base = wr_cnt;
        push_tlv(8'd1, 2, 2, 1'b0, 1'b0, 4'd1, 1'b0);
        push_tlv(8'd5, 1, 1, 1'b1, 1'b1, 4'd2, 1'b0);
        wait_wr(base + 2, "usr_afull");
        snap = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("usr_afull_rd", axi_ib_rd, 0);
            chk("usr_afull_nowr", wr_cnt, snap);
        end
        @(posedge clk);
        #1;
        usr_ib_afull = 1'b0;
        drain("usr_afull");

        // Pass-through full held 10 cycles in the middle of a TLV.
        base = wr_cnt;
        push_tlv(8'd3, 8, 8, 1'b1, 1'b0, 4'd1, 1'b0);
        wait_wr(base + 2, "pt_afull");
        @(posedge clk);
        #1;
        pt_ib_afull = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("pt_afull_rd", axi_ib_rd, 0);
            if (i == 0) snap = wr_cnt;
            else chk("pt_afull_nowr", wr_cnt, snap);
        end
        @(posedge clk);
        #1;
        pt_ib_afull = 1'b0;
        drain("pt_afull");

        // Truncated TLV: tlast on word 2 of a len-5 TLV.
        base = trunc_cnt;
        push_tlv(8'd2, 5, 3, 1'b1, 1'b0, 4'd1, 1'b0);
        push_tlv(8'd3, 1, 1, 1'b1, 1'b0, 4'd1, 1'b0);
        drain("trunc");
        chk("trunc_pulse", trunc_cnt - base, 1);

        // Zero length, zero length with tlast, and a missing header.
        base = len_cnt;
        push_raw({2'b00, 30'h0, 24'd0, 8'd7}, 8'h01, 1'b0);
        push_raw(64'h1111, 8'h00, 1'b0);
        push_raw(64'h2222, 8'h01, 1'b0);
        push_raw(64'h3333, 8'h00, 1'b1);
        push_tlv(8'd1, 1, 1, 1'b1, 1'b0, 4'd1, 1'b0);
        push_raw({2'b00, 30'h0, 24'd0, 8'd5}, 8'h01, 1'b1);
        push_tlv(8'd4, 2, 2, 1'b1, 1'b0, 4'd1, 1'b0);
        push_raw(64'h4444, 8'h00, 1'b0);
        push_raw(64'h5555, 8'h00, 1'b1);
        push_tlv(8'd5, 1, 1, 1'b1, 1'b1, 4'd1, 1'b0);
        drain("len0");
        chk("len_pulses", len_cnt - base, 3);

`ifdef TLVP_SPL_BIP2_CHK_EN
        chk("bip2_clean", bip_cnt, 0);
        push_tlv(8'd6, 2, 2, 1'b1, 1'b0, 4'd1, 1'b1);
        drain("bip2");
        chk("bip2_pulse", bip_cnt, 1);
`else
        chk("bip2_tied", bip_cnt, 0);
`endif

        // Reset in the middle of a TLV abandons it.
        base = wr_cnt;
        push_tlv(8'd8, 6, 6, 1'b1, 1'b0, 4'd1, 1'b0);
        wait_wr(base + 2, "mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        src_q.delete();
        exp_q.delete();
        @(negedge clk);
        chk("midrst_rd", axi_ib_rd, 0);
        chk("midrst_pt_wr", pt_ib_wr, 0);
        chk("midrst_pt_tlv", |pt_ib_tlv, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_tlv(8'd9, 2, 2, 1'b1, 1'b0, 4'd1, 1'b0);
        drain("after_rst");

        // 17 single-word TLVs: ordern runs 1..15, 0, 1.
        for (int k = 0; k < 17; k++)
            push_tlv(8'd9, 1, 1, 1'b0, 1'b0, 4'((1 + k) % 16), 1'b0);
        push_tlv(8'd9, 1, 1, 1'b1, 1'b0, 4'd2, 1'b0);
        drain("wrap");
        chk("final_trunc", trunc_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
